// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter/sequencer for a single-ported
// data memory. Port 0 is the CPU load/store unit, port 1 the debug/DMA
// loader. Each granted request becomes one memory access cycle followed by
// a one-cycle ack carrying the registered read data.
//
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   pN_req/we/addr/wdata  request side of port N (held until pN_ack)
//   pN_ack/rdata/err      completion pulse, read data and range error
//   mwr, moe, ma, mwd     registered memory strobes, byte address, write data
//   mrd                   memory read data (combinational from ma)
//   busy                  high whenever the sequencer is not idle
//
// Build option: define MEM_ARB_RANGE_CHECK_EN to reject accesses whose word
// index (addr>>2) is >= NUM_WORDS; they skip the bus and ack with pN_err=1.
// Without it, pN_err is always 0 and every access goes to memory.

module mem_arbiter #(
  parameter int unsigned NUM_WORDS = 128
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_ack,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_ack,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic        mwr,
  output logic        moe,
  output logic [31:0] ma,
  output logic [31:0] mwd,
  input  logic [31:0] mrd,
  output logic        busy
);

`ifdef MEM_ARB_RANGE_CHECK_EN
  localparam logic RANGE_EN = 1'b1;
`else
  localparam logic RANGE_EN = 1'b0;
`endif

  localparam logic [29:0] WORDS_W = 30'(NUM_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t      state_q;
  logic        last_grant_q;
  logic        winner_q;
  logic        we_q;
  logic        oor_q;
  logic [31:0] rdata_q;
  logic        p0_ack_q, p1_ack_q;
  logic        p0_err_q, p1_err_q;
  logic        mwr_q, moe_q;
  logic [31:0] ma_q, mwd_q;

  logic        grant_d;
  logic        sel_we_d;
  logic        sel_oor_d;
  logic [31:0] sel_addr_d;
  logic [31:0] sel_wdata_d;

  // Winner: the sole requester, or on a tie the port that did not win last.
  always_comb begin
    grant_d = 1'b0;
    if (p0_req && p1_req) begin
      grant_d = ~last_grant_q;
    end else begin
      grant_d = p1_req;
    end
    sel_we_d    = grant_d ? p1_we    : p0_we;
    sel_addr_d  = grant_d ? p1_addr  : p0_addr;
    sel_wdata_d = grant_d ? p1_wdata : p0_wdata;
    sel_oor_d   = RANGE_EN && (sel_addr_d[31:2] >= WORDS_W);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      winner_q     <= 1'b0;
      we_q         <= 1'b0;
      oor_q        <= 1'b0;
      rdata_q      <= '0;
      p0_ack_q     <= 1'b0;
      p1_ack_q     <= 1'b0;
      p0_err_q     <= 1'b0;
      p1_err_q     <= 1'b0;
      mwr_q        <= 1'b0;
      moe_q        <= 1'b0;
      ma_q         <= '0;
      mwd_q        <= '0;
    end else begin
      p0_ack_q <= 1'b0;
      p1_ack_q <= 1'b0;
      p0_err_q <= 1'b0;
      p1_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (p0_req || p1_req) begin
            winner_q <= grant_d;
            we_q     <= sel_we_d;
            oor_q    <= sel_oor_d;
            // A rejected access leaves the bus fully quiet.
            mwr_q    <= sel_we_d & ~sel_oor_d;
            moe_q    <= ~sel_we_d & ~sel_oor_d;
            ma_q     <= sel_oor_d ? '0 : sel_addr_d;
            mwd_q    <= sel_oor_d ? '0 : sel_wdata_d;
            state_q  <= ACCESS;
          end
        end
        ACCESS: begin
          rdata_q <= (we_q || oor_q) ? '0 : mrd;
          mwr_q   <= 1'b0;
          moe_q   <= 1'b0;
          ma_q    <= '0;
          mwd_q   <= '0;
          // Ack/err are raised here so they are visible during RESP.
          if (winner_q) begin
            p1_ack_q <= 1'b1;
            p1_err_q <= oor_q;
          end else begin
            p0_ack_q <= 1'b1;
            p0_err_q <= oor_q;
          end
          state_q <= RESP;
        end
        RESP: begin
          last_grant_q <= winner_q;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign p0_ack   = p0_ack_q;
  assign p1_ack   = p1_ack_q;
  assign p0_err   = p0_err_q;
  assign p1_err   = p1_err_q;
  assign p0_rdata = rdata_q;
  assign p1_rdata = rdata_q;
  assign mwr      = mwr_q;
  assign moe      = moe_q;
  assign ma       = ma_q;
  assign mwd      = mwd_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_ack, p0_err, p1_ack, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mwr, moe, busy;
  logic [31:0] ma, mwd, mrd;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  mem_arbiter #(.NUM_WORDS(128)) dut (
    .clock(clock), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mwr(mwr), .moe(moe), .ma(ma), .mwd(mwd), .mrd(mrd), .busy(busy)
  );

  // Memory model: 128 words, out-of-range writes dropped, reads return 0.
  logic [31:0] mem [128];
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 128; i++) mem[i] <= '0;
    end else if (mwr && (ma[31:9] == 23'd0)) begin
      mem[ma[8:2]] <= mwd;
    end
  end
  assign mrd = (ma[31:9] == 23'd0) ? mem[ma[8:2]] : 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        p0_req;
    logic        p0_we;
    logic [31:0] p0_addr;
    logic [31:0] p0_wdata;
    logic        p1_req;
    logic        p1_we;
    logic [31:0] p1_addr;
    logic [31:0] p1_wdata;
    logic        exp_port;
    logic        exp_mwr;
    logic        exp_moe;
    logic [31:0] exp_ma;
    logic [31:0] exp_mwd;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[11];

  task automatic idle_inputs();
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clock);
    reset = 1'b0;
  endtask

  // Starts on a negedge with the DUT idle; one full transaction, 3 cycles.
  task automatic apply_vec(input vec_t v, input int idx);
    logic [31:0] rd;
    logic        er;
    p0_req = v.p0_req; p0_we = v.p0_we; p0_addr = v.p0_addr; p0_wdata = v.p0_wdata;
    p1_req = v.p1_req; p1_we = v.p1_we; p1_addr = v.p1_addr; p1_wdata = v.p1_wdata;
    @(negedge clock);
    chk($sformatf("v%0d_acc_mwr", idx), {31'd0, mwr}, {31'd0, v.exp_mwr});
    chk($sformatf("v%0d_acc_moe", idx), {31'd0, moe}, {31'd0, v.exp_moe});
    chk($sformatf("v%0d_acc_ma", idx), ma, v.exp_ma);
    chk($sformatf("v%0d_acc_mwd", idx), mwd, v.exp_mwd);
    chk($sformatf("v%0d_acc_busy", idx), {31'd0, busy}, 32'd1);
    chk($sformatf("v%0d_acc_noack", idx), {30'd0, p1_ack, p0_ack}, 32'd0);
    @(negedge clock);
    chk($sformatf("v%0d_p0_ack", idx), {31'd0, p0_ack}, {31'd0, ~v.exp_port});
    chk($sformatf("v%0d_p1_ack", idx), {31'd0, p1_ack}, {31'd0, v.exp_port});
    rd = v.exp_port ? p1_rdata : p0_rdata;
    er = v.exp_port ? p1_err : p0_err;
    chk($sformatf("v%0d_rdata", idx), rd, v.exp_rdata);
    chk($sformatf("v%0d_err", idx), {31'd0, er}, {31'd0, v.exp_err});
    chk($sformatf("v%0d_resp_bus", idx), {30'd0, mwr, moe}, 32'd0);
    idle_inputs();
    @(negedge clock);
    chk($sformatf("v%0d_idle_busy", idx), {31'd0, busy}, 32'd0);
  endtask

  initial begin
    //          p0 req we addr          wdata          p1 req we addr          wdata         port mwr moe ma           mwd            rdata          err
    vecs[0]  = '{1'b1, 1'b1, 32'h10,  32'hDEADBEEF, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 1'b0, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h10,  32'h55555555, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 1'b1, 32'h10,  32'h55555555, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b1, 32'h1FC, 32'h12345678, 1'b1, 1'b1, 1'b0, 32'h1FC, 32'h12345678, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 32'h1FC, 32'h0,        1'b1, 1'b0, 1'b1, 32'h1FC, 32'h0,        32'h12345678, 1'b0};
    // Tie with last_grant=1: port 0 wins.
    vecs[4]  = '{1'b1, 1'b0, 32'h10,  32'h0,        1'b1, 1'b0, 32'h1FC, 32'h0,        1'b0, 1'b0, 1'b1, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
    // Tie with last_grant=0: port 1 wins, port 0 write never happens.
    vecs[5]  = '{1'b1, 1'b1, 32'h20,  32'hA5A5A5A5, 1'b1, 1'b1, 32'h24,  32'h0F0F0F0F, 1'b1, 1'b1, 1'b0, 32'h24,  32'h0F0F0F0F, 32'h0,        1'b0};
    vecs[6]  = '{1'b1, 1'b0, 32'h24,  32'h0,        1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 1'b1, 32'h24,  32'h0,        32'h0F0F0F0F, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 32'h20,  32'h0,        1'b1, 1'b0, 1'b1, 32'h20,  32'h0,        32'h0,        1'b0};
`ifdef MEM_ARB_RANGE_CHECK_EN
    vecs[8]  = '{1'b1, 1'b1, 32'h200, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        1'b1};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 32'h204, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        1'b1};
`else
    vecs[8]  = '{1'b1, 1'b1, 32'h200, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 1'b0, 32'h200, 32'hCAFEF00D, 32'h0,        1'b0};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 32'h204, 32'h0,        1'b1, 1'b0, 1'b1, 32'h204, 32'h0,        32'h0,        1'b0};
`endif
    // Unaligned byte address passes through unmodified.
    vecs[10] = '{1'b1, 1'b0, 32'h1FF, 32'h0,        1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 1'b1, 32'h1FF, 32'h0,        32'h12345678, 1'b0};

    do_reset();
    @(negedge clock);
    chk("rst_acks", {28'd0, p0_ack, p1_ack, p0_err, p1_err}, 32'd0);
    chk("rst_p0_rdata", p0_rdata, 32'd0);
    chk("rst_p1_rdata", p1_rdata, 32'd0);
    chk("rst_strobes", {29'd0, mwr, moe, busy}, 32'd0);
    chk("rst_ma", ma, 32'd0);
    chk("rst_mwd", mwd, 32'd0);

    for (int i = 0; i < 11; i++) apply_vec(vecs[i], i);

    // Port 0 drops req right after grant: ack still issued, no repeat access.
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h40; p0_wdata = 32'h22222222;
    @(negedge clock);
    chk("drop_acc_mwr", {31'd0, mwr}, 32'd1);
    p0_req = 1'b0;
    @(negedge clock);
    chk("drop_ack", {31'd0, p0_ack}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk($sformatf("drop_quiet%0d", k), {29'd0, mwr, p0_ack, busy}, 32'd0);
    end
    idle_inputs();
    apply_vec('{1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                1'b0, 1'b0, 1'b1, 32'h40, 32'h0, 32'h22222222, 1'b0}, 99);

    // Both ports hold requests from reset: strict alternation P0, P1, P0, P1.
    do_reset();
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h8; p0_wdata = 32'h1;
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'hC; p1_wdata = 32'h2;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      chk($sformatf("alt_p0_ack_c%0d", k), {31'd0, p0_ack}, {31'd0, (k == 2 || k == 8)});
      chk($sformatf("alt_p1_ack_c%0d", k), {31'd0, p1_ack}, {31'd0, (k == 5 || k == 11)});
      chk($sformatf("alt_excl_c%0d", k), {31'd0, p0_ack & p1_ack}, 32'd0);
      chk($sformatf("alt_strb_c%0d", k), {31'd0, mwr & moe}, 32'd0);
    end
    idle_inputs();
    @(negedge clock);
    chk("alt_end_busy", {31'd0, busy}, 32'd0);

    // Reset during the access cycle of a port 0 write aborts it.
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h30; p0_wdata = 32'h11111111;
    @(negedge clock);
    chk("abort_acc_mwr", {31'd0, mwr}, 32'd1);
    chk("abort_acc_ma", ma, 32'h30);
    reset = 1'b1;
    idle_inputs();
    @(negedge clock);
    chk("abort_ack", {31'd0, p0_ack}, 32'd0);
    chk("abort_strobes", {29'd0, mwr, moe, busy}, 32'd0);
    chk("abort_ma", ma, 32'd0);
    chk("abort_mwd", mwd, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("abort_after", {29'd0, p0_ack, p1_ack, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
